// File: rtl/beat_scheduler_if.sv
// Metronome control/status bundle between the BPM/meter registers and beat_scheduler.
// master drives tempo, meter and mask; slave (the scheduler) returns beat and click status.
interface beat_scheduler_if;
  logic       run_i;
  logic [9:0] bpm_i;
  logic [1:0] meter_i;
  logic [3:0] beat_mask_i;
  logic       beat_tick_o;
  logic [1:0] beat_idx_o;
  logic       click_o;
  logic       accent_o;
  logic       running_o;

  modport master (
    output run_i, bpm_i, meter_i, beat_mask_i,
    input  beat_tick_o, beat_idx_o, click_o, accent_o, running_o
  );

  modport slave (
    input  run_i, bpm_i, meter_i, beat_mask_i,
    output beat_tick_o, beat_idx_o, click_o, accent_o, running_o
  );
endinterface

// File: rtl/beat_scheduler.sv
// Division-free metronome: phase accumulator beat ticks, bar position and masked click gate.
// Optional ACCENT_EN: accent_o marks beat 0 and its click runs 2*CLICK_CYCLES.
module beat_scheduler #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BPM_MAX      = 999,
  parameter int unsigned CLICK_CYCLES = 2500000,
  parameter int unsigned ACC_W        = 32
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  beat_scheduler_if.slave   bus
);

  localparam logic [ACC_W-1:0] WRAP = ACC_W'(64'(CLK_HZ) * 64'd60);
`ifdef ACCENT_EN
  localparam bit          ACCENT_ON = 1'b1;
  localparam int unsigned CLICK_MAX = 2 * CLICK_CYCLES;
`else
  localparam bit          ACCENT_ON = 1'b0;
  localparam int unsigned CLICK_MAX = CLICK_CYCLES;
`endif
  localparam int unsigned      CNT_W   = $clog2(CLICK_MAX + 1);
  localparam logic [CNT_W-1:0] LEN_N   = CNT_W'(CLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LEN_0   = CNT_W'(CLICK_MAX - 1);
  localparam logic [9:0]       BPM_CAP = 10'(BPM_MAX);

  typedef enum logic [1:0] {S_STOP, S_START, S_RUN} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_tick;
  logic [1:0]       r_idx;
  logic             r_running;
  logic             r_click;
  logic             r_accent;
  logic [CNT_W-1:0] r_cnt;

  logic [9:0]       w_bpm_clamp;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;
  logic [1:0]       w_next_idx;
  logic             w_halt;
  logic             w_fire;
  logic [1:0]       w_fire_idx;
  logic             w_fire_en;
  logic [CNT_W-1:0] w_fire_len;

  always_comb begin
    w_bpm_clamp = (bus.bpm_i > BPM_CAP) ? BPM_CAP : bus.bpm_i;
    w_sum       = r_acc + ACC_W'(w_bpm_clamp);
    w_wrap      = (w_sum >= WRAP);
    // lowering meter below the current index sends the next beat to 0
    w_next_idx  = (r_idx >= bus.meter_i) ? 2'd0 : r_idx + 2'd1;
    w_halt      = (r_state == S_STOP) || ((r_state == S_RUN) && !bus.run_i);
    w_fire      = (r_state == S_START) || ((r_state == S_RUN) && w_wrap);
    w_fire_idx  = (r_state == S_START) ? 2'd0 : w_next_idx;
    w_fire_en   = bus.beat_mask_i[w_fire_idx];
    w_fire_len  = (ACCENT_ON && (w_fire_idx == 2'd0)) ? LEN_0 : LEN_N;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= S_STOP;
      r_acc     <= '0;
      r_tick    <= 1'b0;
      r_idx     <= '0;
      r_running <= 1'b0;
      r_click   <= 1'b0;
      r_accent  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        S_STOP: begin
          r_acc     <= '0;
          r_idx     <= '0;
          r_running <= 1'b0;
          if (bus.run_i) r_state <= S_START;
        end
        S_START: begin
          r_tick    <= 1'b1;
          r_idx     <= '0;
          r_acc     <= '0;
          r_running <= 1'b1;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (!bus.run_i) begin
            r_state   <= S_STOP;
            r_idx     <= '0;
            r_acc     <= '0;
            r_running <= 1'b0;
          end else begin
            // residue is kept on wrap so the average period is exact
            r_acc <= w_wrap ? (w_sum - WRAP) : w_sum;
            if (w_wrap) begin
              r_tick <= 1'b1;
              r_idx  <= w_next_idx;
            end
          end
        end
        default: r_state <= S_STOP;
      endcase

      if (w_halt) begin
        r_click  <= 1'b0;
        r_accent <= 1'b0;
        r_cnt    <= '0;
      end else if (w_fire) begin
        if (w_fire_en) begin
          r_click  <= 1'b1;
          r_cnt    <= w_fire_len;
          r_accent <= ACCENT_ON && (w_fire_idx == 2'd0);
        end else begin
          r_click  <= 1'b0;
          r_cnt    <= '0;
          r_accent <= 1'b0;
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_click  <= 1'b0;
        r_accent <= 1'b0;
      end
    end
  end

  assign bus.beat_tick_o = r_tick;
  assign bus.beat_idx_o  = r_idx;
  assign bus.click_o     = r_click;
  assign bus.accent_o    = r_accent;
  assign bus.running_o   = r_running;

endmodule

// File: tb/tb_beat_scheduler.sv
// Scoreboard bench for beat_scheduler at CLK_HZ=100 (WRAP=6000), CLICK_CYCLES=10.
// Expected tick cycles/indices are queued when tempo stimulus is applied.
module tb_beat_scheduler;
  localparam int unsigned CLK_HZ = 100;
  localparam int unsigned CLICK  = 10;
  localparam int unsigned WRAP   = 6000;
`ifdef ACCENT_EN
  localparam int unsigned LEN0    = 2 * CLICK;
  localparam int unsigned ACC_EXP = 1;
`else
  localparam int unsigned LEN0    = CLICK;
  localparam int unsigned ACC_EXP = 0;
`endif

  logic clock_i   = 1'b0;
  logic reset_n_i = 1'b0;
  beat_scheduler_if bus();

  beat_scheduler #(
    .CLK_HZ(CLK_HZ),
    .BPM_MAX(999),
    .CLICK_CYCLES(CLICK),
    .ACC_W(32)
  ) dut (
    .clock_i(clock_i),
    .reset_n_i(reset_n_i),
    .bus(bus)
  );

  always #5 clock_i = ~clock_i;

  int unsigned cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    int unsigned cyc;
    int unsigned idx;
  } tick_t;
  tick_t sb_q[$];

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic go_to(input int unsigned target);
    while (cyc < target) @(negedge clock_i);
  endtask

  // expected tick m lands ceil((WRAP*m - res0)/bpm) cycles after base
  task automatic push_ticks(input int unsigned base, input int unsigned bpm,
                            input int unsigned count, input int unsigned res0,
                            input int unsigned meter, inout int unsigned idx,
                            output int unsigned last);
    tick_t       t;
    int unsigned need;
    last = base;
    for (int unsigned m = 1; m <= count; m++) begin
      need  = WRAP * m - res0;
      idx   = (idx >= meter) ? 0 : idx + 1;
      t.cyc = base + (need + bpm - 1) / bpm;
      t.idx = idx;
      sb_q.push_back(t);
      last  = t.cyc;
    end
  endtask

  function automatic int unsigned click_len(input int unsigned idx);
    return (idx == 0) ? LEN0 : CLICK;
  endfunction

  always @(negedge clock_i) begin
    tick_t e;
    if (bus.beat_tick_o === 1'b1) begin
      check_eq("tick_expected", (sb_q.size() != 0) ? 1 : 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("tick_cyc", cyc, e.cyc);
        check_eq("tick_idx", bus.beat_idx_o, e.idx);
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      check_eq("tick_missing", cyc, e.cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned c0, idx, last, t, base, u, lows, res, r, s, hold_idx;
    tick_t first;
    bus.run_i       = 1'b0;
    bus.bpm_i       = 10'd60;
    bus.meter_i     = 2'd3;
    bus.beat_mask_i = 4'b1111;

    repeat (3) @(negedge clock_i);
    check_eq("rst_tick",    bus.beat_tick_o, 0);
    check_eq("rst_idx",     bus.beat_idx_o,  0);
    check_eq("rst_click",   bus.click_o,     0);
    check_eq("rst_accent",  bus.accent_o,    0);
    check_eq("rst_running", bus.running_o,   0);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clock_i);
    check_eq("stop_running", bus.running_o, 0);

    // 60 BPM, 4/4, all beats enabled
    c0 = cyc;
    bus.run_i = 1'b1;
    first.cyc = c0 + 2;
    first.idx = 0;
    sb_q.push_back(first);
    idx = 0;
    push_ticks(c0 + 2, 60, 4, 0, 3, idx, last);
    go_to(c0 + 1);
    check_eq("start_running", bus.running_o, 0);
    go_to(c0 + 2);
    check_eq("run_running", bus.running_o, 1);
    check_eq("click_b0_on", bus.click_o, 1);
    check_eq("accent_b0_on", bus.accent_o, ACC_EXP);
    go_to(c0 + 2 + LEN0 - 1);
    check_eq("click_b0_end", bus.click_o, 1);
    check_eq("accent_b0_end", bus.accent_o, ACC_EXP);
    go_to(c0 + 2 + LEN0);
    check_eq("click_b0_off", bus.click_o, 0);
    check_eq("accent_b0_off", bus.accent_o, 0);
    go_to(c0 + 102 + CLICK - 1);
    check_eq("click_b1_end", bus.click_o, 1);
    check_eq("accent_b1", bus.accent_o, 0);
    go_to(c0 + 102 + CLICK);
    check_eq("click_b1_off", bus.click_o, 0);

    // 7 BPM: 858/857 spacing, 7 ticks in exactly 6000 cycles
    go_to(last);
    bus.bpm_i = 10'd7;
    push_ticks(last, 7, 7, 0, 3, idx, last);

    // mid-beat tempo change 60 -> 120 at 40 cycles past a tick
    go_to(last);
    bus.bpm_i = 10'd60;
    push_ticks(last, 60, 1, 0, 3, idx, last);
    t = last;
    go_to(t + 40);
    bus.bpm_i = 10'd120;
    push_ticks(t + 40, 120, 3, 40 * 60, 3, idx, last);

    // mask 0101: clicks on beats 0 and 2 only
    go_to(last);
    bus.beat_mask_i = 4'b0101;
    base = last;
    push_ticks(base, 120, 4, 0, 3, idx, last);
    for (int unsigned k = 1; k <= 4; k++) begin
      go_to(base + 50 * k);
      check_eq("click_mask", bus.click_o, k % 2);
    end

    // meter lowered to 1 while on beat 3
    bus.meter_i = 2'd1;
    push_ticks(last, 120, 3, 0, 1, idx, last);

    // over-range tempo clamps to 999: click stays continuously high
    go_to(last);
    u = last;
    bus.bpm_i       = 10'd1023;
    bus.beat_mask_i = 4'b1111;
    bus.meter_i     = 2'd3;
    push_ticks(u, 999, 20, 0, 3, idx, last);
    lows = 0;
    while (cyc < last) begin
      @(negedge clock_i);
      if (bus.click_o !== 1'b1) lows++;
    end
    check_eq("click_continuous", lows, 0);

    // tempo 0 freezes phase and index
    bus.bpm_i = 10'd0;
    hold_idx = idx;
    res = ((last - u) * 999) % WRAP;
    go_to(last + click_len(idx) - 1);
    check_eq("click_hold_end", bus.click_o, 1);
    go_to(last + click_len(idx));
    check_eq("click_hold_off", bus.click_o, 0);
    go_to(last + 200);
    check_eq("idx_held", bus.beat_idx_o, hold_idx);
    check_eq("running_held", bus.running_o, 1);
    r = cyc;
    bus.bpm_i = 10'd60;
    push_ticks(r, 60, 1, res, 3, idx, last);

    // run_i dropped mid-click
    go_to(last + 3);
    check_eq("click_pre_stop", bus.click_o, 1);
    bus.run_i = 1'b0;
    go_to(last + 4);
    check_eq("stop_click",   bus.click_o,   0);
    check_eq("stop_run",     bus.running_o, 0);
    check_eq("stop_idx",     bus.beat_idx_o, 0);
    check_eq("stop_accent",  bus.accent_o,  0);

    // asynchronous reset mid-click
    repeat (5) @(negedge clock_i);
    s = cyc;
    bus.run_i = 1'b1;
    first.cyc = s + 2;
    first.idx = 0;
    sb_q.push_back(first);
    go_to(s + 5);
    check_eq("click_pre_rst", bus.click_o, 1);
    check_eq("accent_pre_rst", bus.accent_o, ACC_EXP);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("arst_click",   bus.click_o,    0);
    check_eq("arst_running", bus.running_o,  0);
    check_eq("arst_accent",  bus.accent_o,   0);
    check_eq("arst_tick",    bus.beat_tick_o, 0);
    bus.run_i = 1'b0;
    @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check_eq("post_rst_running", bus.running_o, 0);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
